mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency word memory between the instruction-fetch port and the data load/store port of the MIPS machine. It is needed once instruction and data memory are merged into one array. The block:
- Arbitrates between the two requesters, with data winning by default and a starvation limit protecting fetch.
- Latches the winning request and holds it on the memory port until the memory signals ready.
- Returns a one-cycle done pulse to the winner.
- Aborts any access that exceeds a timeout and raises a sticky error.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data load/store port and the shared memory port.
// The slave view belongs to the arbiter; the master view drives requests and models memory.
interface mem_port_arbiter_if;
  // Fetch port
  logic        i_req;
  logic [29:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  // Data port
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  // Memory port
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency word memory between instruction fetch and
// data load/store. Data wins conflicts unless fetch has been passed over STARVE_LIMIT
// times; accesses that never see mem_ready are aborted after TIMEOUT busy cycles.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
  // wait_q is 0 in the first busy cycle, so TIMEOUT-1 marks the last allowed cycle
  localparam logic [WW-1:0] WaitLast = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          mem_we_q, mem_we_d;
  logic [29:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          err_q, err_d;
  logic          busy, expired, finish;

  // State and latched memory-port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  // Arbitration, request latching, wait counting and timeout detection
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    busy        = (state_q != StIdle);
    expired     = busy && !bus.mem_ready && (wait_q == WaitLast);
    finish      = busy && (bus.mem_ready || expired);

    unique case (state_q)
      StIdle: begin
        if (!bus.i_req) begin
          starve_d = '0;
        end
        if (bus.i_req && (!bus.d_req || starve_q >= StarveMax)) begin
          state_d    = StBusyI;
          wait_d     = '0;
          starve_d   = '0;
          mem_addr_d = bus.i_addr;
          mem_we_d   = 1'b0;
        end else if (bus.d_req) begin
          state_d     = StBusyD;
          wait_d      = '0;
          mem_addr_d  = bus.d_addr;
          mem_we_d    = bus.d_we;
          mem_wdata_d = bus.d_wdata;
          // Count data grants that made a waiting fetch stand aside
          if (bus.i_req && starve_q < StarveMax) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StBusyI, StBusyD: begin
        if (finish) begin
          state_d  = StIdle;
          mem_we_d = 1'b0;
          if (expired) begin
            err_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Done pulses and read data are combinational; a reset cycle never reports completion
  assign bus.i_done    = finish && (state_q == StBusyI) && !reset;
  assign bus.d_done    = finish && (state_q == StBusyD) && !reset;
  assign bus.i_rdata   = (bus.i_done && !expired) ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata   = (bus.d_done && !expired) ? bus.mem_rdata : 32'h0;
  assign bus.mem_req   = busy;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(2),
    .TIMEOUT     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  string order;

  initial begin
    order         = "DDIDDI";
    reset         = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    look();
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_done", {30'h0, bus.i_done, bus.d_done}, 32'h0);
    check("rst_mem_err", 32'(bus.mem_err), 32'h0);
    tick();
    reset = 1'b0;

    // Fetch alone, memory ready in the third busy cycle
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h100000;
    look();
    check("f_idle_req", 32'(bus.mem_req), 32'h0);
    tick();
    look();
    check("f_mem_req", 32'(bus.mem_req), 32'h1);
    check("f_mem_addr", 32'(bus.mem_addr), 32'h100000);
    check("f_mem_we", 32'(bus.mem_we), 32'h0);
    check("f_done_c1", {30'h0, bus.i_done, bus.d_done}, 32'h0);
    tick();
    look();
    check("f_done_c2", {30'h0, bus.i_done, bus.d_done}, 32'h0);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h8C220004;
    look();
    check("f_done_c3", {30'h0, bus.i_done, bus.d_done}, 32'h2);
    check("f_rdata", bus.i_rdata, 32'h8C220004);
    check("f_d_rdata", bus.d_rdata, 32'h0);
    tick();
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b0;
    look();
    check("f_after_req", 32'(bus.mem_req), 32'h0);
    check("f_after_done", {30'h0, bus.i_done, bus.d_done}, 32'h0);

    // Store alone, zero-wait memory (ready already high in IDLE, which must be ignored)
    tick();
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 30'h4;
    bus.d_wdata   = 32'hDEADBEEF;
    bus.mem_ready = 1'b1;
    look();
    check("s_idle_done", {30'h0, bus.i_done, bus.d_done}, 32'h0);
    tick();
    look();
    check("s_mem_we", 32'(bus.mem_we), 32'h1);
    check("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("s_mem_addr", 32'(bus.mem_addr), 32'h4);
    check("s_done", {30'h0, bus.i_done, bus.d_done}, 32'h1);
    tick();
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b0;
    look();
    check("s_after_we", 32'(bus.mem_we), 32'h0);
    check("s_after_req", 32'(bus.mem_req), 32'h0);
    check("s_after_done", {30'h0, bus.i_done, bus.d_done}, 32'h0);

    // Conflict: both held, zero-wait memory; expect D,D,I,D,D,I
    tick();
    bus.i_req     = 1'b1;
    bus.i_addr    = 30'h3A;
    bus.d_req     = 1'b1;
    bus.d_addr    = 30'h1B;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h12345678;
    for (int k = 0; k < 6; k++) begin
      look();
      check($sformatf("c%0d_idle", k), 32'(bus.mem_req), 32'h0);
      tick();
      look();
      if (order[k] == "I") begin
        check($sformatf("c%0d_done_I", k), {30'h0, bus.i_done, bus.d_done}, 32'h2);
        check($sformatf("c%0d_addr_I", k), 32'(bus.mem_addr), 32'h3A);
      end else begin
        check($sformatf("c%0d_done_D", k), {30'h0, bus.i_done, bus.d_done}, 32'h1);
        check($sformatf("c%0d_addr_D", k), 32'(bus.mem_addr), 32'h1B);
      end
      tick();
      if (order[k] == "I") begin
        check($sformatf("c%0d_starve", k), 32'(dut.starve_q), 32'h0);
      end
    end
    bus.i_req     = 1'b0;
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;

    // Timeout: load never answered, abort in the 4th busy cycle
    tick();
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 30'h8;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    for (int c = 1; c <= 3; c++) begin
      look();
      check($sformatf("t_wait%0d", c), {30'h0, bus.i_done, bus.d_done}, 32'h0);
      tick();
    end
    look();
    check("t_done", {30'h0, bus.i_done, bus.d_done}, 32'h1);
    check("t_rdata", bus.d_rdata, 32'h0);
    check("t_err_before", 32'(bus.mem_err), 32'h0);
    tick();
    bus.d_req = 1'b0;
    look();
    check("t_err_set", 32'(bus.mem_err), 32'h1);
    check("t_idle_req", 32'(bus.mem_req), 32'h0);
    tick();
    bus.i_req     = 1'b1;
    bus.i_addr    = 30'h55;
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    look();
    check("t_fetch_done", {30'h0, bus.i_done, bus.d_done}, 32'h2);
    check("t_fetch_rdata", bus.i_rdata, 32'hCAFEF00D);
    check("t_err_held", 32'(bus.mem_err), 32'h1);
    tick();
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset in the second BUSY_D cycle with a fetch also pending
    tick();
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h77;
    bus.d_req  = 1'b1;
    bus.d_addr = 30'hC;
    tick();
    look();
    check("r_busy_d", 32'(bus.mem_addr), 32'hC);
    tick();
    reset = 1'b1;
    look();
    check("r_no_done", {30'h0, bus.i_done, bus.d_done}, 32'h0);
    tick();
    reset     = 1'b0;
    bus.d_req = 1'b0;
    look();
    check("r_mem_req", 32'(bus.mem_req), 32'h0);
    check("r_mem_err", 32'(bus.mem_err), 32'h0);
    check("r_no_done2", {30'h0, bus.i_done, bus.d_done}, 32'h0);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    look();
    check("r_fetch_addr", 32'(bus.mem_addr), 32'h77);
    check("r_fetch_done", {30'h0, bus.i_done, bus.d_done}, 32'h2);
    check("r_fetch_rdata", bus.i_rdata, 32'h0BADF00D);
    tick();
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b0;

    // Requester changes address mid-access; ready in IDLE afterwards is ignored
    tick();
    bus.d_req  = 1'b1;
    bus.d_addr = 30'h10;
    tick();
    bus.d_addr = 30'h20;
    look();
    check("a_addr_c1", 32'(bus.mem_addr), 32'h10);
    tick();
    look();
    check("a_addr_c2", 32'(bus.mem_addr), 32'h10);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00C0FFEE;
    look();
    check("a_addr_c3", 32'(bus.mem_addr), 32'h10);
    check("a_done", {30'h0, bus.i_done, bus.d_done}, 32'h1);
    check("a_rdata", bus.d_rdata, 32'h00C0FFEE);
    tick();
    bus.d_req = 1'b0;
    look();
    check("a_idle_ready", {30'h0, bus.i_done, bus.d_done}, 32'h0);
    check("a_idle_rdata", bus.d_rdata, 32'h0);
    tick();
    look();
    check("a_idle_req", 32'(bus.mem_req), 32'h0);
    check("a_idle_ready2", {30'h0, bus.i_done, bus.d_done}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
